fifo_queue: RTL and testbench
=============================

Name: fifo_queue

Overview:
16-deep, 8-bit first-in/first-out buffer. It is the companion to the team's LIFO stack: words are written at the tail and read from the opposite end, the head. It serves as elastic buffering between producer and consumer logic in the same clock domain. It adds full/empty/occupancy status, and a sticky error flag for overflow and underflow.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH = 16

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
push  input  1  write data_in at tail this cycle
pop  input  1  read word at head this cycle
data_in  input  DATA_WIDTH  word to write
data_out  output  DATA_WIDTH  last popped word, registered
data_valid  output  1  one-cycle pulse: data_out updated this cycle
full  output  1  count == 16
empty  output  1  count == 0
count  output  ADDR_WIDTH+1  current occupancy, 0..16
error  output  1  sticky overflow/underflow flag

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk.
- No input registering. push, pop and data_in are sampled on the same rising edge they are presented.
- Reset values:
  - data_out = 0, data_valid = 0, error = 0, count = 0.
  - empty = 1, full = 0.
  - Write pointer = 0, read pointer = 0.
  - Memory contents are not cleared.
- Reset dominates: push and pop in a reset cycle are ignored.
- Reset mid-stream discards all stored words. The next pop after reset is an underflow.
- Acceptance rules (evaluated on pre-edge state):
  - pop_ok = pop && !empty
  - push_ok = push && (!full || pop_ok)
  - Push when full with a simultaneous pop: both are accepted; count stays 16.
  - Push and pop when empty: push accepted, pop rejected as underflow. There is no write-through bypass.
- Write path: on push_ok, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr + 1.
- Read path:
  - On pop_ok, data_out <= mem[rd_ptr], rd_ptr <= rd_ptr + 1, data_valid <= 1.
  - Read latency: data_out and data_valid are valid the edge after the pop is presented.
  - Without pop_ok, data_valid <= 0 and data_out holds its value.
- Pointers wrap modulo 16. Full and empty are derived from count, not from pointer equality.
- count update:
  - +1 on push_ok only.
  - -1 on pop_ok only.
  - Unchanged when both or neither are accepted.
- full and empty are registered-equivalent functions of count. They are valid the cycle after the update.
- Errors:
  - Overflow: push && full && !pop_ok. The write is dropped and error <= 1.
  - Underflow: pop && empty. data_out holds, data_valid stays 0, and error <= 1.
  - error is sticky until reset. Subsequent legal operations continue normally.
- Occupancy state (derived from count, used for coverage):
  - EMPTY (0) -> PARTIAL on push_ok.
  - PARTIAL -> FULL when count reaches 16.
  - PARTIAL -> EMPTY when count reaches 0.
  - FULL -> PARTIAL on pop_ok without push_ok.
  - EMPTY <-> FULL directly is impossible.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - DEPTH = 2**ADDR_WIDTH.
  - Occupancy state encoding EMPTY/PARTIAL/FULL, shared with the stack's testbench for coverage reuse.
- One sub-module: fifo_queue_ram.
  - 16 x DATA_WIDTH register file.
  - One synchronous write port (we, waddr, wdata).
  - One registered read port (re, raddr, rdata).
  - No reset on the array.
- Pointer, count and error logic stay in the top.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 cycles -> data_out 0x11, 0x22, 0x33 with data_valid high one cycle after each pop; count returns to 0; empty = 1; error = 0.
- Push 16 words 0x00..0x0F -> full = 1, count = 16. A 17th push of 0xAA -> error = 1. 16 pops then return 0x00..0x0F; 0xAA never appears.
- Fill to 16, then push 0x55 with pop in the same cycle -> data_out = 0x00, count stays 16, error = 0. 0x55 emerges as the 16th subsequent pop.
- From reset, pop -> error = 1, data_valid = 0, data_out = 0x00. Then push 0x7E and pop -> data_out = 0x7E; error still 1.
- Wrap-around:
  - Repeat 40 cycles alternating push k/pop (k = 0..39) with occupancy held at 3 -> pops return an in-order sequence; pointers wrap past 15 without error.
- Reset mid-stream:
  - With count = 5, assert reset together with push 0x99 -> count = 0, empty = 1, error = 0, data_valid = 0.
  - Next pop flags underflow.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// fifo_queue_pkg
// Shared definitions for the 16-deep FIFO and its testbenches.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default word and pointer widths
//   DEPTH                           : number of storage entries (2**ADDR_WIDTH_DEF)
//   occ_state_t                     : occupancy encoding (EMPTY/PARTIAL/FULL), also used
//                                     by the LIFO stack's bench for coverage
package fifo_queue_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_t;

endpackage

// File: rtl/fifo_queue_if.sv
// fifo_queue_if
// Bundles the FIFO's producer/consumer signals.
//   push, pop, data_in                  : requests from the user (master side)
//   data_out, data_valid                : registered read result, valid pulse
//   full, empty, count, error           : status
//   occ_state                           : debug view of the occupancy state machine
//
// Handshake: push and pop are single-cycle requests sampled on the rising edge.
// A push is taken when not full (or when a pop is taken the same cycle); a pop is
// taken when not empty. A taken pop returns its word on data_out one edge later,
// marked by a one-cycle data_valid pulse. Rejected requests set the sticky error.
interface fifo_queue_if
   import fifo_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  error;
   occ_state_t            occ_state;

   modport master (
      output push, pop, data_in,
      input  data_out, data_valid, full, empty, count, error, occ_state
   );

   modport slave (
      input  push, pop, data_in,
      output data_out, data_valid, full, empty, count, error, occ_state
   );

endinterface

// File: rtl/fifo_queue_ram.sv
// fifo_queue_ram
// 2**ADDR_WIDTH x DATA_WIDTH register file with one synchronous write port and
// one registered read port. The array itself is never reset; only the read
// register is cleared so the FIFO's data_out starts at zero.
//   clk, rst            : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port; rdata updates the edge after re, else holds
module fifo_queue_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A read and write to the same address in one cycle returns the old word,
   // which is what a full FIFO doing push+pop needs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fifo_queue.sv
// fifo_queue
// 16-deep, 8-bit FIFO: written at the tail, read from the head, with occupancy
// status and a sticky overflow/underflow error flag. Single clock domain.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; dominates push/pop
//   bus   : fifo_queue_if slave (push/pop/data_in in; data_out, data_valid,
//           full, empty, count, error, occ_state out)
module fifo_queue
   import fifo_queue_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   fifo_queue_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_d;
   logic                  data_valid_q;
   logic                  error_q;
   logic                  full_w;
   logic                  empty_w;
   logic                  pop_ok;
   logic                  push_ok;
   logic                  overflow;
   logic                  underflow;
   occ_state_t            state_q;
   occ_state_t            state_d;

   // Status comes from the registered count, never from pointer equality.
   assign full_w  = (count_q == COUNT_FULL);
   assign empty_w = (count_q == '0);

   // A pop frees a slot in the same cycle, so a full FIFO may accept push+pop.
   // An empty FIFO never forwards the pushed word to a simultaneous pop.
   assign pop_ok    = bus.pop && !empty_w;
   assign push_ok   = bus.push && (!full_w || pop_ok);
   assign overflow  = bus.push && full_w && !pop_ok;
   assign underflow = bus.pop && empty_w;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   fifo_queue_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .we    (push_ok && !reset),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .re    (pop_ok && !reset),
      .raddr (rd_ptr),
      .rdata (bus.data_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         data_valid_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count_q      <= count_d;
         data_valid_q <= pop_ok;
         if (overflow || underflow) begin
            error_q <= 1'b1;
         end
      end
   end

   // Occupancy state machine: tracks the same information as count in
   // three coarse states for coverage; EMPTY and FULL never connect directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= OCC_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OCC_EMPTY: begin
            if (push_ok) begin
               state_d = OCC_PARTIAL;
            end
         end
         OCC_PARTIAL: begin
            if (count_d == COUNT_FULL) begin
               state_d = OCC_FULL;
            end else if (count_d == '0) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (pop_ok && !push_ok) begin
               state_d = OCC_PARTIAL;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
   end

   assign bus.data_valid = data_valid_q;
   assign bus.full       = full_w;
   assign bus.empty      = empty_w;
   assign bus.count      = count_q;
   assign bus.error      = error_q;
   assign bus.occ_state  = state_q;

endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue
// Directed testbench for fifo_queue: one task per scenario, each with inline
// comparisons against hand-computed values, followed by a single summary line.
module tb_fifo_queue;
   import fifo_queue_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   fifo_queue_if bus ();

   fifo_queue dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present inputs, take one rising edge, then sample 1 ns later.
   task automatic step(input logic p, input logic q, input logic [7:0] d);
      bus.push    = p;
      bus.pop     = q;
      bus.data_in = d;
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.count !== 5'd0) begin
         failures++; $display("FAIL reset_count got=%0d exp=0", bus.count);
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", bus.empty, bus.full);
      end
      checks++;
      if (bus.error !== 1'b0 || bus.data_valid !== 1'b0) begin
         failures++; $display("FAIL reset_err_dv got error=%b dv=%b exp 0 0", bus.error, bus.data_valid);
      end
      checks++;
      if (bus.data_out !== 8'h00) begin
         failures++; $display("FAIL reset_dout got=%h exp=00", bus.data_out);
      end
      checks++;
      if (bus.occ_state !== OCC_EMPTY) begin
         failures++; $display("FAIL reset_occ got=%0d exp=%0d", bus.occ_state, OCC_EMPTY);
      end
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, vals[i]);
      checks++;
      if (bus.count !== 5'd3 || bus.occ_state !== OCC_PARTIAL) begin
         failures++; $display("FAIL basic_count got=%0d occ=%0d exp=3 occ=1", bus.count, bus.occ_state);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (bus.data_valid !== 1'b1 || bus.data_out !== vals[i]) begin
            failures++;
            $display("FAIL basic_pop%0d got dv=%b dout=%h exp dv=1 dout=%h", i, bus.data_valid, bus.data_out, vals[i]);
         end
      end
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h33) begin
         failures++; $display("FAIL basic_idle got dv=%b dout=%h exp dv=0 dout=33", bus.data_valid, bus.data_out);
      end
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.error !== 1'b0 || bus.occ_state !== OCC_EMPTY) begin
         failures++;
         $display("FAIL basic_end got count=%0d empty=%b error=%b occ=%0d exp 0 1 0 0", bus.count, bus.empty, bus.error, bus.occ_state);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
      checks++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.error !== 1'b0 || bus.occ_state !== OCC_FULL) begin
         failures++;
         $display("FAIL ovf_fill got full=%b count=%0d error=%b occ=%0d exp 1 16 0 2", bus.full, bus.count, bus.error, bus.occ_state);
      end
      step(1'b1, 1'b0, 8'hAA);
      checks++;
      if (bus.error !== 1'b1 || bus.count !== 5'd16) begin
         failures++; $display("FAIL ovf_flag got error=%b count=%0d exp error=1 count=16", bus.error, bus.count);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (bus.data_valid !== 1'b1 || bus.data_out !== 8'(i)) begin
            failures++; $display("FAIL ovf_pop%0d got dv=%b dout=%h exp dv=1 dout=%h", i, bus.data_valid, bus.data_out, 8'(i));
         end
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.error !== 1'b1) begin
         failures++; $display("FAIL ovf_end got empty=%b count=%0d error=%b exp 1 0 1", bus.empty, bus.count, bus.error);
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_v;
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
      step(1'b1, 1'b1, 8'h55);
      checks++;
      if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b1 || bus.count !== 5'd16 || bus.error !== 1'b0 || bus.full !== 1'b1) begin
         failures++;
         $display("FAIL fpp_both got dout=%h dv=%b count=%0d error=%b full=%b exp 00 1 16 0 1",
                  bus.data_out, bus.data_valid, bus.count, bus.error, bus.full);
      end
      for (int i = 1; i <= 16; i++) begin
         exp_v = (i == 16) ? 8'h55 : 8'(i);
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (bus.data_out !== exp_v) begin
            failures++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, bus.data_out, exp_v);
         end
      end
      checks++;
      if (bus.empty !== 1'b1 || bus.error !== 1'b0) begin
         failures++; $display("FAIL fpp_end got empty=%b error=%b exp 1 0", bus.empty, bus.error);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.error !== 1'b1 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.count !== 5'd0) begin
         failures++;
         $display("FAIL udf_flag got error=%b dv=%b dout=%h count=%0d exp 1 0 00 0", bus.error, bus.data_valid, bus.data_out, bus.count);
      end
      // Push and pop together while empty: no bypass, the pop underflows.
      step(1'b1, 1'b1, 8'h7E);
      checks++;
      if (bus.data_valid !== 1'b0 || bus.count !== 5'd1) begin
         failures++; $display("FAIL udf_nobypass got dv=%b count=%0d exp dv=0 count=1", bus.data_valid, bus.count);
      end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h7E || bus.data_valid !== 1'b1 || bus.error !== 1'b1) begin
         failures++; $display("FAIL udf_recover got dout=%h dv=%b error=%b exp 7e 1 1", bus.data_out, bus.data_valid, bus.error);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_q [$];
      logic [7:0] exp_v;
      int         bad;
      bad = 0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 8'(k));
         exp_q.push_back(8'(k));
      end
      for (int k = 3; k < 40; k++) begin
         step(1'b1, 1'b0, 8'(k));
         exp_q.push_back(8'(k));
         step(1'b0, 1'b1, 8'h00);
         exp_v = exp_q.pop_front();
         checks++;
         if (bus.data_valid !== 1'b1 || bus.data_out !== exp_v) begin
            failures++; bad++;
            if (bad < 5) $display("FAIL wrap_pop k=%0d got dv=%b dout=%h exp dv=1 dout=%h", k, bus.data_valid, bus.data_out, exp_v);
         end
      end
      checks++;
      if (bus.count !== 5'd3 || bus.error !== 1'b0) begin
         failures++; $display("FAIL wrap_end got count=%0d error=%b exp count=3 error=0", bus.count, bus.error);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
      step(1'b0, 1'b1, 8'h00);
      step(1'b1, 1'b0, 8'hC5);
      checks++;
      if (bus.count !== 5'd5 || bus.data_out !== 8'hC0) begin
         failures++; $display("FAIL mid_pre got count=%0d dout=%h exp count=5 dout=c0", bus.count, bus.data_out);
      end
      reset = 1'b1;
      step(1'b1, 1'b1, 8'h99);
      reset = 1'b0;
      checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.error !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin
         failures++;
         $display("FAIL mid_reset got count=%0d empty=%b error=%b dv=%b dout=%h exp 0 1 0 0 00",
                  bus.count, bus.empty, bus.error, bus.data_valid, bus.data_out);
      end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.error !== 1'b1 || bus.data_valid !== 1'b0 || bus.count !== 5'd0) begin
         failures++; $display("FAIL mid_udf got error=%b dv=%b count=%0d exp 1 0 0", bus.error, bus.data_valid, bus.count);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b0;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.data_in = 8'h00;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_underflow();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
